// File: rtl/pwm_step_sequencer.sv
// Move-command sequencer: takes (period, steps, dir) commands, runs the PWM generator,
// counts its pulses and stops it after the last pulse. Optional queue: `PWM_SEQ_QUEUE_EN.
module pwm_step_sequencer #(
  parameter int W       = 32,
  parameter int MIN_PER = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_period,
  input  logic [W-1:0] cmd_steps,
  input  logic         cmd_dir,
  input  logic         abort,
  input  logic         pwm_pulse,
  output logic [W-1:0] pwm_f,
  output logic         pwm_rst,
  output logic         dir,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] step_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] period_q, period_d;
  logic [W-1:0] steps_q, steps_d;
  logic [W-1:0] count_q, count_d;
  logic         dir_q, dir_d;
  logic         pulse_q;
  logic         pwm_rst_q, pwm_rst_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  logic         xfer, cmd_bad, cmd_zero, rise;
  logic [W-1:0] count_inc;

`ifdef PWM_SEQ_QUEUE_EN
  logic         q_valid_q, q_valid_d;
  logic [W-1:0] q_period_q, q_period_d;
  logic [W-1:0] q_steps_q, q_steps_d;
  logic         q_dir_q, q_dir_d;

  assign cmd_ready = reset && !q_valid_q;
`else
  assign cmd_ready = reset && (state_q == S_IDLE);
`endif

  assign xfer      = cmd_valid && cmd_ready;
  assign cmd_bad   = (cmd_period < W'(MIN_PER));
  assign cmd_zero  = (cmd_steps == '0);
  // Rising edge seen between the raw input and its registered copy.
  assign rise      = pwm_pulse && !pulse_q;
  assign count_inc = count_q + W'(rise);

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    steps_d   = steps_q;
    count_d   = count_q;
    dir_d     = dir_q;
    pwm_rst_d = pwm_rst_q;
    done_d    = 1'b0;
    err_d     = err_q || (xfer && cmd_bad);
`ifdef PWM_SEQ_QUEUE_EN
    q_valid_d  = q_valid_q;
    q_period_d = q_period_q;
    q_steps_d  = q_steps_q;
    q_dir_d    = q_dir_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef PWM_SEQ_QUEUE_EN
        if (q_valid_q) begin
          period_d  = q_period_q;
          steps_d   = q_steps_q;
          dir_d     = q_dir_q;
          count_d   = '0;
          q_valid_d = 1'b0;
          state_d   = S_LOAD;
        end else
`endif
        if (xfer) begin
          if (cmd_bad || cmd_zero) begin
            done_d = 1'b1;
          end else begin
            period_d = cmd_period;
            steps_d  = cmd_steps;
            dir_d    = cmd_dir;
            count_d  = '0;
            state_d  = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (abort) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          pwm_rst_d = 1'b0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        count_d = count_inc;
        if ((count_inc == steps_q) || abort) state_d = S_DRAIN;
      end
      default: begin
        // Hold the generator running until the final pulse has fallen.
        if (!pulse_q) begin
          pwm_rst_d = 1'b1;
          done_d    = 1'b1;
          state_d   = S_IDLE;
`ifdef PWM_SEQ_QUEUE_EN
          if (q_valid_q && !abort) begin
            period_d  = q_period_q;
            steps_d   = q_steps_q;
            dir_d     = q_dir_q;
            count_d   = '0;
            q_valid_d = 1'b0;
            state_d   = S_LOAD;
          end
`endif
        end
      end
    endcase
`ifdef PWM_SEQ_QUEUE_EN
    if (state_q != S_IDLE) begin
      if (abort) begin
        q_valid_d = 1'b0;
      end else if (xfer) begin
        if (cmd_bad || cmd_zero) begin
          done_d = 1'b1;
        end else begin
          q_valid_d  = 1'b1;
          q_period_d = cmd_period;
          q_steps_d  = cmd_steps;
          q_dir_d    = cmd_dir;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      period_q  <= '0;
      steps_q   <= '0;
      count_q   <= '0;
      dir_q     <= 1'b0;
      pulse_q   <= 1'b0;
      pwm_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      steps_q   <= steps_d;
      count_q   <= count_d;
      dir_q     <= dir_d;
      pulse_q   <= pwm_pulse;
      pwm_rst_q <= pwm_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

`ifdef PWM_SEQ_QUEUE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_valid_q  <= 1'b0;
      q_period_q <= '0;
      q_steps_q  <= '0;
      q_dir_q    <= 1'b0;
    end else begin
      q_valid_q  <= q_valid_d;
      q_period_q <= q_period_d;
      q_steps_q  <= q_steps_d;
      q_dir_q    <= q_dir_d;
    end
  end
`endif

  assign pwm_f      = period_q;
  assign pwm_rst    = pwm_rst_q;
  assign dir        = dir_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign step_count = count_q;

endmodule

// File: tb/tb_pwm_step_sequencer.sv
// Directed bench for pwm_step_sequencer driving a behavioural PWM generator
// (pulse high for the first half of each period, held low while pwm_rst=1).
module tb_pwm_step_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_period = '0;
  logic [W-1:0] cmd_steps = '0;
  logic         cmd_dir = 1'b0;
  logic         abort = 1'b0;
  logic         pwm_pulse;
  logic [W-1:0] pwm_f;
  logic         pwm_rst;
  logic         dir;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] step_count;

  int total = 0;
  int bad = 0;

  pwm_step_sequencer #(.W(W), .MIN_PER(2)) dut (
    .clk(clk), .reset(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_period(cmd_period), .cmd_steps(cmd_steps), .cmd_dir(cmd_dir),
    .abort(abort), .pwm_pulse(pwm_pulse), .pwm_f(pwm_f), .pwm_rst(pwm_rst),
    .dir(dir), .busy(busy), .done(done), .err(err), .step_count(step_count)
  );

  always #5 clk = ~clk;

  // Behavioural PWM generator
  logic [W-1:0] pcnt = '0;
  logic         pulse_r = 1'b0;
  assign pwm_pulse = pulse_r;
  always @(posedge clk) begin
    if (pwm_rst) begin
      pcnt    <= '0;
      pulse_r <= 1'b0;
    end else begin
      pcnt    <= (pcnt >= pwm_f - 1) ? '0 : pcnt + 1;
      pulse_r <= (pcnt < (pwm_f >> 1));
    end
  end

  // Pulse / done monitor sampled on the falling edge
  int cyc = 0, rises = 0, dones = 0, fall_cyc = 0, done_cyc = 0;
  logic pulse_prev = 1'b0;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (pwm_pulse && !pulse_prev) rises = rises + 1;
    if (!pwm_pulse && pulse_prev) fall_cyc = cyc;
    if (done) begin
      dones = dones + 1;
      done_cyc = cyc;
    end
    pulse_prev = pwm_pulse;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_mon();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n = 0;
    while (done !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
  endtask

  task automatic send(input int per, input int stp, input logic d);
    cmd_period = per;
    cmd_steps  = stp;
    cmd_dir    = d;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
  endtask

  int r0, d0, n;
  bit ready_while_busy;

  initial begin
    // Reset state
    tick(); tick();
    check("rst_pwm_rst", 64'(pwm_rst), 64'd1);
    check("rst_pwm_f", 64'(pwm_f), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_step_count", 64'(step_count), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // Basic move: period 10, 3 steps, dir 1
    r0 = rises;
    send(10, 3, 1'b1);
    check("t1_load_busy", 64'(busy), 64'd1);
    check("t1_load_pwm_f", 64'(pwm_f), 64'd10);
    check("t1_load_dir", 64'(dir), 64'd1);
    check("t1_load_pwm_rst", 64'(pwm_rst), 64'd1);
    check("t1_load_count", 64'(step_count), 64'd0);
    tick();
    check("t1_run_pwm_rst", 64'(pwm_rst), 64'd0);
    wait_done("t1", 300);
    check("t1_busy_at_done", 64'(busy), 64'd0);
    check("t1_pwm_rst_at_done", 64'(pwm_rst), 64'd1);
    check("t1_step_count", 64'(step_count), 64'd3);
    check("t1_pwm_f_held", 64'(pwm_f), 64'd10);
    sync_mon();
    check("t1_rises", 64'(rises - r0), 64'd3);
    check("t1_fall_to_done", 64'(done_cyc - fall_cyc), 64'd2);
    tick();
    check("t1_done_one_cycle", 64'(done), 64'd0);
    check("t1_count_holds", 64'(step_count), 64'd3);

    // Zero steps and illegal period
    r0 = rises;
    send(10, 0, 1'b0);
    check("t2_zero_done", 64'(done), 64'd1);
    check("t2_zero_busy", 64'(busy), 64'd0);
    check("t2_zero_pwm_rst", 64'(pwm_rst), 64'd1);
    check("t2_zero_err", 64'(err), 64'd0);
    tick();
    send(1, 5, 1'b0);
    check("t2_bad_err", 64'(err), 64'd1);
    check("t2_bad_done", 64'(done), 64'd1);
    check("t2_bad_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 20; i++) tick();
    sync_mon();
    check("t2_pwm_rst_held", 64'(pwm_rst), 64'd1);
    check("t2_no_pulses", 64'(rises - r0), 64'd0);
    check("t2_err_sticky", 64'(err), 64'd1);

    // Abort after the 5th rising edge
    tick();
    r0 = rises;
    send(20, 100, 1'b0);
    n = 0;
    while ((rises - r0) < 5 && n < 400) begin
      tick();
      n++;
    end
    check("t3_reached_5", 64'(rises - r0), 64'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done("t3", 100);
    check("t3_step_count", 64'(step_count), 64'd5);
    check("t3_pwm_rst", 64'(pwm_rst), 64'd1);
    check("t3_busy", 64'(busy), 64'd0);
    sync_mon();
    check("t3_rises", 64'(rises - r0), 64'd5);
    check("t3_fall_to_done", 64'(done_cyc - fall_cyc), 64'd2);

    // Reset mid-move
    tick();
    r0 = rises;
    send(10, 50, 1'b1);
    n = 0;
    while ((rises - r0) < 2 && n < 200) begin
      tick();
      n++;
    end
    check("t4_running", 64'(busy), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t4_pwm_rst", 64'(pwm_rst), 64'd1);
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_step_count", 64'(step_count), 64'd0);
    check("t4_err_cleared", 64'(err), 64'd0);
    check("t4_dir", 64'(dir), 64'd0);
    sync_mon();
    d0 = dones;
    for (int i = 0; i < 15; i++) tick();
    sync_mon();
    check("t4_no_done", 64'(dones - d0), 64'd0);

`ifdef PWM_SEQ_QUEUE_EN
    // Queue: (10,2) then (6,4) back to back
    tick();
    r0 = rises;
    d0 = dones;
    send(10, 2, 1'b0);
    check("t5_q_ready_in_load", 64'(cmd_ready), 64'd1);
    send(6, 4, 1'b1);
    check("t5_q_full", 64'(cmd_ready), 64'd0);
    wait_done("t5a", 200);
    check("t5a_step_count", 64'(step_count), 64'd0);
    check("t5a_busy", 64'(busy), 64'd1);
    check("t5a_pwm_rst", 64'(pwm_rst), 64'd1);
    check("t5a_pwm_f", 64'(pwm_f), 64'd6);
    check("t5a_dir", 64'(dir), 64'd1);
    sync_mon();
    check("t5a_rises", 64'(rises - r0), 64'd2);
    tick();
    check("t5_rst_one_cycle", 64'(pwm_rst), 64'd0);
    wait_done("t5b", 200);
    check("t5b_step_count", 64'(step_count), 64'd4);
    check("t5b_busy", 64'(busy), 64'd0);
    sync_mon();
    check("t5b_rises", 64'(rises - r0), 64'd6);
    check("t5_two_dones", 64'(dones - d0), 64'd2);
`else
    // No queue: second command held valid during the first move
    tick();
    r0 = rises;
    send(6, 2, 1'b0);
    cmd_period = 8;
    cmd_steps  = 1;
    cmd_dir    = 1'b1;
    cmd_valid  = 1'b1;
    ready_while_busy = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy && cmd_ready) ready_while_busy = 1'b1;
      tick();
      n++;
    end
    check("t6_first_done", 64'(done), 64'd1);
    check("t6_ready_low_busy", 64'(ready_while_busy), 64'd0);
    check("t6_first_count", 64'(step_count), 64'd2);
    n = 0;
    while (!cmd_ready && n < 10) begin
      tick();
      n++;
    end
    tick();
    cmd_valid = 1'b0;
    check("t6_second_busy", 64'(busy), 64'd1);
    check("t6_second_pwm_f", 64'(pwm_f), 64'd8);
    check("t6_second_dir", 64'(dir), 64'd1);
    wait_done("t6b", 200);
    check("t6_second_count", 64'(step_count), 64'd1);
    sync_mon();
    check("t6_rises", 64'(rises - r0), 64'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
